// File: rtl/program_counter_unit.sv
// program_counter_unit
// Instruction-fetch / program-counter stage. Owns the PC and runs the
// instruction-memory bus handshake. It applies control-unit PC operations
// (inc, branch, jump, jsb, ret, int, reti) and keeps a return-address stack
// with sticky overflow and underflow flags.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clkEn_i             clock enable for every state update
//   fetch_req_i         request fetch at current PC
//   inst_ack_i          instruction-memory acknowledge
//   inst_cyc_o/stb_o    bus cycle / strobe (high while in BUS)
//   inst_adr_o          fetch address (= pc_o)
//   fetch_done_o        one-cycle pulse after ack accepted
//   pc_en_i, pc_op_i    apply PC operation (IDLE only)
//   addr_i, disp_i      absolute target / signed branch displacement
//   pc_o                current PC
//   stack_*_o           return-stack status and sticky error flags
module program_counter_unit #(
  parameter int unsigned          ADDR_W       = 12,
  parameter int unsigned          STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = 12'h000,
  parameter logic [ADDR_W-1:0]    INT_VECTOR   = 12'h001
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clkEn_i,
  input  logic              fetch_req_i,
  input  logic              inst_ack_i,
  output logic              inst_cyc_o,
  output logic              inst_stb_o,
  output logic [ADDR_W-1:0] inst_adr_o,
  output logic              fetch_done_o,
  input  logic              pc_en_i,
  input  logic [2:0]        pc_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        disp_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              stack_empty_o,
  output logic              stack_full_o,
  output logic              stack_ovf_o,
  output logic              stack_unf_o
);

  localparam int unsigned DISP_W = 8;
  localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(STACK_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } bus_state_e;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_BRANCH = 3'b010,
    OP_JUMP   = 3'b011,
    OP_JSB    = 3'b100,
    OP_RET    = 3'b101,
    OP_INT    = 3'b110,
    OP_RETI   = 3'b111
  } pc_op_e;

  bus_state_e        r_state;
  bus_state_e        w_state_next;
  logic              r_fetch_done;
  logic              w_fetch_done_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [SP_W-1:0]   r_sp;
  logic [SP_W-1:0]   w_sp_next;
  logic              r_ovf;
  logic              r_unf;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic              w_push;
  logic              w_op_fire;
  logic              w_full;
  logic              w_empty;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_top_idx;
  logic [ADDR_W-1:0] w_disp_ext;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = IDX_W'(r_sp);
  assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_disp_ext = {{(ADDR_W-DISP_W){disp_i[DISP_W-1]}}, disp_i};
  // PC operations are only honoured while the bus is idle.
  assign w_op_fire  = pc_en_i && clkEn_i && (r_state == S_IDLE);

  // Bus FSM next state; a request is ignored during the done-pulse cycle.
  always_comb begin
    w_state_next      = r_state;
    w_fetch_done_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fetch_req_i && !r_fetch_done) w_state_next = S_BUS;
      end
      S_BUS: begin
        if (inst_ack_i) begin
          w_state_next      = S_IDLE;
          w_fetch_done_next = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // PC / stack next-state for the selected operation.
  always_comb begin
    w_pc_next = r_pc;
    w_sp_next = r_sp;
    w_push    = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (w_op_fire) begin
      case (pc_op_e'(pc_op_i))
        OP_INC:    w_pc_next = r_pc + ADDR_W'(1);
        OP_BRANCH: w_pc_next = r_pc + w_disp_ext;
        OP_JUMP:   w_pc_next = addr_i;
        OP_JSB, OP_INT: begin
          w_pc_next = (pc_op_e'(pc_op_i) == OP_INT) ? INT_VECTOR : addr_i;
          // A push into a full stack is dropped but the PC still loads.
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_push    = 1'b1;
            w_sp_next = r_sp + SP_W'(1);
          end
        end
        OP_RET, OP_RETI: begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_pc_next = r_stack[w_top_idx];
            w_sp_next = r_sp - SP_W'(1);
          end
        end
        default: w_pc_next = r_pc;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_fetch_done <= 1'b0;
      r_pc         <= RESET_VECTOR;
      r_sp         <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else if (clkEn_i) begin
      r_state      <= w_state_next;
      r_fetch_done <= w_fetch_done_next;
      r_pc         <= w_pc_next;
      r_sp         <= w_sp_next;
      r_ovf        <= r_ovf | w_ovf_set;
      r_unf        <= r_unf | w_unf_set;
    end
  end

  // Return-stack storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) r_stack[w_push_idx] <= r_pc;
  end

  assign inst_cyc_o    = (r_state == S_BUS);
  assign inst_stb_o    = (r_state == S_BUS);
  assign inst_adr_o    = r_pc;
  assign pc_o          = r_pc;
  assign fetch_done_o  = r_fetch_done;
  assign stack_empty_o = w_empty;
  assign stack_full_o  = w_full;
  assign stack_ovf_o   = r_ovf;
  assign stack_unf_o   = r_unf;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed self-checking bench for program_counter_unit.
module tb_program_counter_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clkEn_i;
  logic        fetch_req_i;
  logic        inst_ack_i;
  logic        inst_cyc_o;
  logic        inst_stb_o;
  logic [11:0] inst_adr_o;
  logic        fetch_done_o;
  logic        pc_en_i;
  logic [2:0]  pc_op_i;
  logic [11:0] addr_i;
  logic [7:0]  disp_i;
  logic [11:0] pc_o;
  logic        stack_empty_o;
  logic        stack_full_o;
  logic        stack_ovf_o;
  logic        stack_unf_o;

  int n_tests = 0;
  int n_fail  = 0;

  program_counter_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .clkEn_i(clkEn_i),
    .fetch_req_i(fetch_req_i), .inst_ack_i(inst_ack_i),
    .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o),
    .inst_adr_o(inst_adr_o), .fetch_done_o(fetch_done_o),
    .pc_en_i(pc_en_i), .pc_op_i(pc_op_i), .addr_i(addr_i), .disp_i(disp_i),
    .pc_o(pc_o), .stack_empty_o(stack_empty_o), .stack_full_o(stack_full_o),
    .stack_ovf_o(stack_ovf_o), .stack_unf_o(stack_unf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [11:0] a, input logic [7:0] d);
    pc_en_i = 1'b1; pc_op_i = op; addr_i = a; disp_i = d;
    step();
    pc_en_i = 1'b0; pc_op_i = 3'b000;
  endtask

  initial begin
    rst_i = 1'b1; clkEn_i = 1'b1; fetch_req_i = 1'b0; inst_ack_i = 1'b0;
    pc_en_i = 1'b0; pc_op_i = 3'b000; addr_i = '0; disp_i = '0;
    #2;
    check("rst_pc", 32'(pc_o), 32'h000);
    check("rst_cyc", 32'(inst_cyc_o), 32'd0);
    check("rst_stb", 32'(inst_stb_o), 32'd0);
    check("rst_done", 32'(fetch_done_o), 32'd0);
    check("rst_empty", 32'(stack_empty_o), 32'd1);
    check("rst_full", 32'(stack_full_o), 32'd0);
    check("rst_ovf", 32'(stack_ovf_o), 32'd0);
    check("rst_unf", 32'(stack_unf_o), 32'd0);
    step(); step();
    rst_i = 1'b0;
    step();

    // Fetch with ack two cycles after the request.
    fetch_req_i = 1'b1;
    step();
    fetch_req_i = 1'b0;
    check("fetch_cyc1", 32'(inst_cyc_o), 32'd1);
    check("fetch_stb1", 32'(inst_stb_o), 32'd1);
    check("fetch_adr", 32'(inst_adr_o), 32'h000);
    step();
    check("fetch_cyc2", 32'(inst_cyc_o), 32'd1);
    check("fetch_done_early", 32'(fetch_done_o), 32'd0);
    inst_ack_i = 1'b1;
    step();
    inst_ack_i = 1'b0;
    check("fetch_cyc_end", 32'(inst_cyc_o), 32'd0);
    check("fetch_done_hi", 32'(fetch_done_o), 32'd1);
    step();
    check("fetch_done_lo", 32'(fetch_done_o), 32'd0);
    check("fetch_pc", 32'(pc_o), 32'h000);

    // Branch / increment arithmetic.
    do_op(3'b011, 12'h010, 8'h00);
    do_op(3'b010, 12'h000, 8'hFC);
    check("branch_neg", 32'(pc_o), 32'h00C);
    do_op(3'b011, 12'h010, 8'h00);
    do_op(3'b010, 12'h000, 8'h7F);
    check("branch_pos", 32'(pc_o), 32'h08F);
    do_op(3'b011, 12'hFFF, 8'h00);
    do_op(3'b001, 12'h000, 8'h00);
    check("inc_wrap", 32'(pc_o), 32'h000);

    // Single call / return.
    do_op(3'b011, 12'h020, 8'h00);
    do_op(3'b100, 12'h300, 8'h00);
    check("jsb_pc", 32'(pc_o), 32'h300);
    check("jsb_empty", 32'(stack_empty_o), 32'd0);
    do_op(3'b101, 12'h000, 8'h00);
    check("ret_pc", 32'(pc_o), 32'h020);
    check("ret_empty", 32'(stack_empty_o), 32'd1);

    // Fill and overflow the stack; pushes save 050,100..106.
    do_op(3'b011, 12'h050, 8'h00);
    for (int i = 0; i < 8; i++) do_op(3'b100, 12'h100 + 12'(i), 8'h00);
    check("fill_full", 32'(stack_full_o), 32'd1);
    check("fill_ovf_clear", 32'(stack_ovf_o), 32'd0);
    check("fill_pc", 32'(pc_o), 32'h107);
    do_op(3'b100, 12'h108, 8'h00);
    check("ovf_set", 32'(stack_ovf_o), 32'd1);
    check("ovf_pc", 32'(pc_o), 32'h108);
    check("ovf_full", 32'(stack_full_o), 32'd1);
    do_op(3'b101, 12'h000, 8'h00);
    check("pop_top", 32'(pc_o), 32'h106);
    check("pop_not_full", 32'(stack_full_o), 32'd0);
    for (int i = 0; i < 7; i++) do_op(3'b101, 12'h000, 8'h00);
    check("pop_last", 32'(pc_o), 32'h050);
    check("pop_empty", 32'(stack_empty_o), 32'd1);
    check("unf_clear", 32'(stack_unf_o), 32'd0);
    do_op(3'b101, 12'h000, 8'h00);
    check("unf_set", 32'(stack_unf_o), 32'd1);
    check("unf_pc", 32'(pc_o), 32'h050);
    check("ovf_sticky", 32'(stack_ovf_o), 32'd1);

    // Interrupt entry and return.
    do_op(3'b011, 12'h045, 8'h00);
    do_op(3'b110, 12'h000, 8'h00);
    check("int_pc", 32'(pc_o), 32'h001);
    check("int_empty", 32'(stack_empty_o), 32'd0);
    do_op(3'b111, 12'h000, 8'h00);
    check("reti_pc", 32'(pc_o), 32'h045);

    // PC op while in BUS is ignored.
    fetch_req_i = 1'b1;
    step();
    fetch_req_i = 1'b0;
    check("bus_adr", 32'(inst_adr_o), 32'h045);
    do_op(3'b011, 12'h777, 8'h00);
    check("bus_jump_ignored", 32'(pc_o), 32'h045);
    inst_ack_i = 1'b1;
    step();
    inst_ack_i = 1'b0;
    check("bus2_done", 32'(fetch_done_o), 32'd1);
    step();

    // Combined op and fetch: updated PC appears on the bus address.
    fetch_req_i = 1'b1;
    do_op(3'b001, 12'h000, 8'h00);
    fetch_req_i = 1'b0;
    check("comb_cyc", 32'(inst_cyc_o), 32'd1);
    check("comb_adr", 32'(inst_adr_o), 32'h046);
    inst_ack_i = 1'b1;
    step();
    inst_ack_i = 1'b0;
    step();

    // Clock enable low freezes everything.
    clkEn_i = 1'b0;
    fetch_req_i = 1'b1;
    do_op(3'b001, 12'h000, 8'h00);
    fetch_req_i = 1'b0;
    check("cken_pc", 32'(pc_o), 32'h046);
    check("cken_cyc", 32'(inst_cyc_o), 32'd0);
    clkEn_i = 1'b1;

    // Reset during BUS with a pushed stack.
    do_op(3'b100, 12'h200, 8'h00);
    fetch_req_i = 1'b1;
    step();
    fetch_req_i = 1'b0;
    check("pre_rst_cyc", 32'(inst_cyc_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_cyc", 32'(inst_cyc_o), 32'd0);
    check("mid_rst_stb", 32'(inst_stb_o), 32'd0);
    check("mid_rst_pc", 32'(pc_o), 32'h000);
    check("mid_rst_empty", 32'(stack_empty_o), 32'd1);
    check("mid_rst_ovf", 32'(stack_ovf_o), 32'd0);
    check("mid_rst_unf", 32'(stack_unf_o), 32'd0);
    step();
    rst_i = 1'b0;
    inst_ack_i = 1'b1;
    step();
    inst_ack_i = 1'b0;
    check("post_rst_done", 32'(fetch_done_o), 32'd0);
    check("post_rst_cyc", 32'(inst_cyc_o), 32'd0);
    step();
    check("post_rst_done2", 32'(fetch_done_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
